// File: rtl/qsys_system_tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: register map, CTRL/STATUS bit
// positions and the FSM state encoding.
package qsys_system_tone_sequencer_pkg;

  // Register addresses (Avalon word addresses)
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CTRL     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_DURATION = 3'd3;
  localparam logic [2:0] ADDR_LEVEL    = 3'd4;

  // CTRL bits
  localparam int CTRL_IRQ_EN_BIT = 0;
  localparam int CTRL_RUN_BIT    = 1;
  localparam int CTRL_FLUSH_BIT  = 2;

  // STATUS bits
  localparam int STAT_EMPTY_BIT    = 0;
  localparam int STAT_FULL_BIT     = 1;
  localparam int STAT_PLAYING_BIT  = 2;
  localparam int STAT_OVERFLOW_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } tone_state_e;

endpackage

// File: rtl/qsys_system_tone_fifo.sv
// Synchronous FIFO holding note entries {half_period, duration}.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   push_i, data_i   write request and entry; dropped when full unless a pop
//                    happens in the same cycle
//   pop_i            read request, ignored when empty
//   flush_i          empties the FIFO; overrides push and pop
//   data_o           head entry (combinational, valid when !empty_o)
//   level_o          occupancy 0..DEPTH
//   full_o, empty_o  status flags
module qsys_system_tone_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_L   = LVL_W'(1);
  localparam logic [AW-1:0]    ONE_A   = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == DEPTH_L);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ONE_A;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ONE_A;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + ONE_L;
        2'b01:   level_q <= level_q - ONE_L;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/qsys_system_tone_sequencer.sv
// Avalon-MM tone sequencer. The CPU queues {half_period, duration} notes;
// each note plays as a 50% square wave on pwm_out for `duration` rising
// edges of tick_in. irq requests a refill when the queue runs low or a push
// was dropped.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   address, chipselect,
//   write_n, writedata          Avalon-MM slave write/select
//   readdata                    registered read data (1-cycle latency)
//   irq                         registered level interrupt
//   tick_in                     timer timeout pulse (clk domain)
//   pwm_out                     speaker drive
// Bus handshake: a write is accepted in every cycle where chipselect=1 and
// write_n=0 (no wait states); readdata reflects the register selected by
// address in the previous cycle.
module qsys_system_tone_sequencer
  import qsys_system_tone_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PERIOD_W   = 16,
  parameter int DUR_W      = 16,
  parameter int LOW_WATER  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  input  logic        tick_in,
  output logic        pwm_out
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0]    LOW_WATER_L = LVL_W'(LOW_WATER);
  localparam logic [PERIOD_W-1:0] ONE_P       = PERIOD_W'(1);
  localparam logic [DUR_W-1:0]    ONE_D       = DUR_W'(1);

  // Bus decode
  logic wr_stb, wr_status, wr_ctrl, wr_period, wr_dur, flush_stb;
  assign wr_stb    = chipselect & ~write_n;
  assign wr_status = wr_stb & (address == ADDR_STATUS);
  assign wr_ctrl   = wr_stb & (address == ADDR_CTRL);
  assign wr_period = wr_stb & (address == ADDR_PERIOD);
  assign wr_dur    = wr_stb & (address == ADDR_DURATION);
  assign flush_stb = wr_ctrl & writedata[CTRL_FLUSH_BIT];

  // Registers
  logic [1:0]          ctrl_q, ctrl_d;
  logic [PERIOD_W-1:0] period_stage_q;
  logic [DUR_W-1:0]    last_dur_q;
  logic                overflow_q, overflow_d;
  logic [15:0]         readdata_q, readdata_d;
  logic                irq_q, irq_d;
  logic                tick_prev_q, tick;

  // FSM and note counters
  tone_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
  logic [PERIOD_W-1:0] half_cnt_q, half_cnt_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic                pwm_q, pwm_d;
  logic                pop;
  logic                run_eff;

  // FIFO
  logic [PERIOD_W+DUR_W-1:0] head;
  logic [PERIOD_W-1:0]       head_period;
  logic [DUR_W-1:0]          head_dur;
  logic [LVL_W-1:0]          level;
  logic                      fifo_full, fifo_empty, push, push_drop;

  assign push        = wr_dur & ~flush_stb;
  assign push_drop   = push & fifo_full & ~pop;
  assign head_period = head[PERIOD_W+DUR_W-1:DUR_W];
  assign head_dur    = head[DUR_W-1:0];

  qsys_system_tone_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PERIOD_W + DUR_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .data_i  ({period_stage_q, writedata[DUR_W-1:0]}),
    .pop_i   (pop),
    .flush_i (flush_stb),
    .data_o  (head),
    .level_o (level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A CTRL write takes effect on the FSM in the same cycle, so clearing run
  // leaves PLAY at the write edge.
  assign ctrl_d  = wr_ctrl ? writedata[1:0] : ctrl_q;
  assign run_eff = ctrl_d[CTRL_RUN_BIT];

  // Rising-edge detect: a held tick_in level counts once.
  assign tick = tick_in & ~tick_prev_q;

  always_comb begin
    overflow_d = overflow_q;
    if (wr_status)      overflow_d = 1'b0;
    else if (push_drop) overflow_d = 1'b1;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STATUS: begin
        readdata_d[STAT_OVERFLOW_BIT] = overflow_q;
        readdata_d[STAT_PLAYING_BIT]  = (state_q != ST_IDLE);
        readdata_d[STAT_FULL_BIT]     = fifo_full;
        readdata_d[STAT_EMPTY_BIT]    = fifo_empty;
      end
      ADDR_CTRL:     readdata_d[1:0] = ctrl_q;
      ADDR_PERIOD:   readdata_d = 16'(period_stage_q);
      ADDR_DURATION: readdata_d = 16'(last_dur_q);
      ADDR_LEVEL:    readdata_d = 16'(level);
      default:       readdata_d = '0;
    endcase
  end

  assign irq_d = ctrl_q[CTRL_IRQ_EN_BIT] & ((level <= LOW_WATER_L) | overflow_q);

  // FSM next state and counters
  always_comb begin
    state_d      = state_q;
    cur_period_d = cur_period_q;
    half_cnt_d   = half_cnt_q;
    dur_cnt_d    = dur_cnt_q;
    pwm_d        = 1'b0;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_eff && !fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop          = 1'b1;
        cur_period_d = head_period;
        half_cnt_d   = (head_period == '0) ? '0 : head_period - ONE_P;
        dur_cnt_d    = (head_dur == '0) ? ONE_D : head_dur;
        state_d      = ST_PLAY;
      end
      ST_PLAY: begin
        pwm_d = pwm_q;
        if (cur_period_q == '0) begin
          pwm_d = 1'b0;
        end else if (half_cnt_q == '0) begin
          pwm_d      = ~pwm_q;
          half_cnt_d = cur_period_q - ONE_P;
        end else begin
          half_cnt_d = half_cnt_q - ONE_P;
        end
        if (tick) begin
          if (dur_cnt_q <= ONE_D) begin
            pwm_d   = 1'b0;
            state_d = fifo_empty ? ST_IDLE : ST_LOAD;
          end else begin
            dur_cnt_d = dur_cnt_q - ONE_D;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Stopping or flushing abandons the current note immediately.
    if (flush_stb || !run_eff) begin
      state_d = ST_IDLE;
      pop     = 1'b0;
      pwm_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q         <= '0;
      period_stage_q <= '0;
      last_dur_q     <= '0;
      overflow_q     <= 1'b0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
      tick_prev_q    <= 1'b0;
      state_q        <= ST_IDLE;
      cur_period_q   <= '0;
      half_cnt_q     <= '0;
      dur_cnt_q      <= '0;
      pwm_q          <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      if (wr_period) period_stage_q <= writedata[PERIOD_W-1:0];
      if (wr_dur)    last_dur_q     <= writedata[DUR_W-1:0];
      overflow_q   <= overflow_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
      tick_prev_q  <= tick_in;
      state_q      <= state_d;
      cur_period_q <= cur_period_d;
      half_cnt_q   <= half_cnt_d;
      dur_cnt_q    <= dur_cnt_d;
      pwm_q        <= pwm_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
  assign pwm_out  = pwm_q;

endmodule

// File: tb/tb_qsys_system_tone_sequencer.sv
// Directed bench for the tone sequencer. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_qsys_system_tone_sequencer;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_DUR    = 3'd3;
  localparam logic [2:0] A_LEVEL  = 3'd4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic        tick_in = 1'b0;
  logic [15:0] readdata;
  logic        irq;
  logic        pwm_out;

  always #5 clk = ~clk;

  qsys_system_tone_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .tick_in    (tick_in),
    .pwm_out    (pwm_out)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    address = addr; writedata = data; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [15:0] data);
    @(negedge clk);
    address = addr; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    data = readdata;
    chipselect = 1'b0;
  endtask

  task automatic expect_read(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    logic [15:0] got;
    exp_q.push_back(exp);
    bus_read(addr, got);
    check(tag, 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic tick_pulse();
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); tick_in = 1'b0;
  endtask

  // Cycles until pwm_out changes, bounded at 200.
  task automatic wait_pwm_change(output int cycles);
    logic prev;
    prev = pwm_out;
    cycles = 0;
    while (cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (pwm_out !== prev) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int highs;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readdata", 32'(readdata), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    reset = 1'b0;
    expect_read("rst_status", A_STATUS, 16'h0001);
    expect_read("rst_level", A_LEVEL, 16'h0000);
    expect_read("rst_ctrl", A_CTRL, 16'h0000);

    // Note {3,2}: half period 3 clk, two ticks
    bus_write(A_PERIOD, 16'd3);
    bus_write(A_DUR, 16'd2);
    expect_read("t1_level", A_LEVEL, 16'd1);
    expect_read("t1_dur_rd", A_DUR, 16'd2);
    expect_read("t1_per_rd", A_PERIOD, 16'd3);
    bus_write(A_CTRL, 16'h0002);
    wait_pwm_change(cyc);
    check("t1_first_edge", 32'(cyc), 32'd4);  // LOAD cycle + 3 clk half period
    wait_pwm_change(cyc);
    check("t1_half_a", 32'(cyc), 32'd3);
    wait_pwm_change(cyc);
    check("t1_half_b", 32'(cyc), 32'd3);
    repeat (100) @(negedge clk);
    tick_pulse();
    expect_read("t1_still_playing", A_STATUS, 16'h0005);
    repeat (100) @(negedge clk);
    tick_pulse();
    check("t1_end_pwm", 32'(pwm_out), 32'h0);
    expect_read("t1_end_status", A_STATUS, 16'h0001);

    // Rest then period 1
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_PERIOD, 16'd0);
    bus_write(A_DUR, 16'd1);
    bus_write(A_PERIOD, 16'd1);
    bus_write(A_DUR, 16'd1);
    bus_write(A_CTRL, 16'h0002);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
    check("t2_rest_highs", 32'(highs), 32'd0);
    expect_read("t2_rest_status", A_STATUS, 16'h0004);
    tick_pulse();
    check("t2_gap_pwm", 32'(pwm_out), 32'h0);
    wait_pwm_change(cyc);
    check("t2_first_edge", 32'(cyc), 32'd2);
    wait_pwm_change(cyc);
    check("t2_half_a", 32'(cyc), 32'd1);
    wait_pwm_change(cyc);
    check("t2_half_b", 32'(cyc), 32'd1);
    tick_pulse();
    expect_read("t2_end_status", A_STATUS, 16'h0001);

    // Overflow with 17 pushes, run=0, irq_en=1
    bus_write(A_CTRL, 16'h0001);
    bus_write(A_PERIOD, 16'd2);
    for (int i = 0; i < 17; i++) bus_write(A_DUR, 16'd1);
    expect_read("t3_level", A_LEVEL, 16'd16);
    expect_read("t3_status", A_STATUS, 16'h000A);
    check("t3_irq_ovf", 32'(irq), 32'h1);
    bus_write(A_STATUS, 16'h0000);
    expect_read("t3_status_clr", A_STATUS, 16'h0002);
    check("t3_irq_full", 32'(irq), 32'h0);
    expect_read("t3_unmapped5", 3'd5, 16'h0000);
    expect_read("t3_unmapped7", 3'd7, 16'h0000);

    // Drain to the low-water mark
    bus_write(A_CTRL, 16'h0003);
    for (int i = 0; i < 10; i++) tick_pulse();
    expect_read("t4_level5", A_LEVEL, 16'd5);
    check("t4_irq_lvl5", 32'(irq), 32'h0);
    tick_pulse();
    @(negedge clk);
    check("t4_irq_pop_cycle", 32'(irq), 32'h0);
    @(negedge clk);
    check("t4_irq_lvl4", 32'(irq), 32'h1);

    // Stop mid-note, then flush
    bus_write(A_CTRL, 16'h0001);
    check("t5_stop_pwm", 32'(pwm_out), 32'h0);
    expect_read("t5_stop_status", A_STATUS, 16'h0000);
    expect_read("t5_stop_level", A_LEVEL, 16'd4);
    bus_write(A_CTRL, 16'h0005);
    expect_read("t5_flush_level", A_LEVEL, 16'd0);
    expect_read("t5_flush_status", A_STATUS, 16'h0001);
    expect_read("t5_flush_ctrl", A_CTRL, 16'h0001);
    check("t5_irq_empty", 32'(irq), 32'h1);

    // Held tick_in counts once
    bus_write(A_CTRL, 16'h0000);
    bus_write(A_PERIOD, 16'd2);
    bus_write(A_DUR, 16'd2);
    bus_write(A_CTRL, 16'h0002);
    repeat (5) @(negedge clk);
    tick_in = 1'b1;
    repeat (50) @(negedge clk);
    tick_in = 1'b0;
    expect_read("t6_held_status", A_STATUS, 16'h0005);
    tick_pulse();
    expect_read("t6_end_status", A_STATUS, 16'h0001);
    check("t6_irq_dis", 32'(irq), 32'h0);

    // Reset during PLAY
    bus_write(A_DUR, 16'd3);
    bus_write(A_CTRL, 16'h0003);
    wait_pwm_change(cyc);
    check("t7_pwm_high", 32'(pwm_out), 32'h1);
    check("t7_irq_high", 32'(irq), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("t7_rst_pwm", 32'(pwm_out), 32'h0);
    check("t7_rst_irq", 32'(irq), 32'h0);
    check("t7_rst_readdata", 32'(readdata), 32'h0);
    reset = 1'b0;
    expect_read("t7_status", A_STATUS, 16'h0001);
    expect_read("t7_ctrl", A_CTRL, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
